// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEPTH_WORDS_DEF = 32;
  localparam int DMEM_LATENCY_DEF     = 10;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    for (v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter; done_o flags the final wait cycle (count == 1).
module dmem_latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed access latency.
// Optional DMEM_RANGE_CHECK_EN adds err_o for addresses beyond the array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF,
  parameter int LATENCY     = DMEM_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
`ifdef DMEM_RANGE_CHECK_EN
  output logic        err_o,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam int CNT_W = clog2(LATENCY + 1);

  // Handshake: a request is accepted at any rising edge in IDLE with req_i=1;
  // ack_o pulses for one cycle LATENCY cycles later, and the initiator must
  // drop req_i at the edge where it sees ack_o or a new transaction starts.

  dmem_state_e      r_state;
  dmem_state_e      w_state_next;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_done;
  logic             w_enter_resp;
  logic [IDX_W-1:0] w_addr_idx;
  logic             w_addr_oor;
  logic [IDX_W-1:0] w_src_idx;
  logic             w_src_we;
  logic [31:0]      w_src_wdata;
  logic             w_src_err;
  logic             w_unused_addr;

  assign w_addr_idx    = addr_i[IDX_W+1:2];
  assign w_unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  assign w_addr_oor = ((addr_i >> (IDX_W + 2)) != 32'd0);
`else
  assign w_addr_oor = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && req_i;

  dmem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (start_i),
    .i_load     (w_accept),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .i_en       (r_state == BUSY),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (req_i) w_state_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (w_done) w_state_next = RESP;
      RESP: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // With LATENCY=1 RESP is entered straight from IDLE, so use the live inputs.
  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
  assign w_src_idx    = (r_state == IDLE) ? w_addr_idx : r_idx;
  assign w_src_we     = (r_state == IDLE) ? we_i       : r_we;
  assign w_src_wdata  = (r_state == IDLE) ? wdata_i    : r_wdata;
  assign w_src_err    = (r_state == IDLE) ? w_addr_oor : r_err;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we    <= we_i;
        r_idx   <= w_addr_idx;
        r_wdata <= wdata_i;
        r_err   <= w_addr_oor;
      end
      if (w_enter_resp) begin
        if (w_src_err)     r_rdata <= '0;
        else if (w_src_we) r_rdata <= w_src_wdata;
        else               r_rdata <= r_mem[w_src_idx];
      end
    end
  end

  // Store commits only on the edge leaving RESP, so a reset before then drops it.
  always_ff @(posedge clk_i) begin
    if ((r_state == RESP) && r_we && !r_err) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ack_o       = (r_state == RESP);
  assign busy_o      = (r_state != IDLE);
  assign rdata_o     = r_rdata;
  assign dbg_state_o = r_state;
`ifdef DMEM_RANGE_CHECK_EN
  assign err_o       = (r_state == RESP) && r_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=10 main instance, LATENCY=1 side instance).
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 10;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        ack_o, busy_o;
  logic [31:0] rdata_o;
  logic [1:0]  dbg_state_o;
  logic        req_1, we_1;
  logic [31:0] addr_1, wdata_1;
  logic        ack_1, busy_1;
  logic [31:0] rdata_1;
  logic [1:0]  dbg_state_1;
`ifdef DMEM_RANGE_CHECK_EN
  logic        err_o, err_1;
`endif

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i       (clk_i),
    .start_i     (start_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
`ifdef DMEM_RANGE_CHECK_EN
    .err_o       (err_o),
`endif
    .dbg_state_o (dbg_state_o)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i       (clk_i),
    .start_i     (start_i),
    .req_i       (req_1),
    .we_i        (we_1),
    .addr_i      (addr_1),
    .wdata_i     (wdata_1),
    .ack_o       (ack_1),
    .rdata_o     (rdata_1),
    .busy_o      (busy_1),
`ifdef DMEM_RANGE_CHECK_EN
    .err_o       (err_1),
`endif
    .dbg_state_o (dbg_state_1)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acks   = 0;
  int          n_txn    = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: word-addressed array, index = (addr / 4) mod DEPTH.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit mutate);
    int idx;
    bit oor;
    int n;
    bit seen;
    int busy_low;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
    oor = (addr >= 32'(DEPTH * 4));
`else
    oor = 1'b0;
`endif
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    if (oor) begin
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b1);
    end else if (we) begin
      model_mem[idx] = wd;
      exp_q.push_back(wd); exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(model_mem[idx]); exp_err_q.push_back(1'b0);
    end
    n_txn++;
    @(posedge clk_i);
    n = 0; seen = 1'b0; busy_low = 0;
    while (!seen && n < LAT + 20) begin
      @(negedge clk_i);
      n++;
      if (!busy_o) busy_low++;
      if (ack_o) seen = 1'b1;
      else if (mutate && n == 3) begin
        we_i = 1'b1; addr_i = 32'h4; wdata_i = $urandom();
      end
    end
    req_i = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", 32'(n), 32'(LAT));
    check("busy_during", 32'(busy_low), 32'd0);
    @(negedge clk_i);
    check("ack_one_cycle", 32'({ack_o, busy_o}), 32'd0);
  endtask

  task automatic reset_mid_store();
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'hCAFEF00D;
    @(posedge clk_i);
    repeat (5) @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_ack", 32'(ack_o), 32'd0);
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
  endtask

  task automatic issue1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp);
    @(negedge clk_i);
    req_1 = 1'b1; we_1 = we; addr_1 = addr; wdata_1 = wd;
    @(posedge clk_i);
    @(negedge clk_i);
    check("l1_ack", 32'(ack_1), 32'd1);
    check("l1_rdata", rdata_1, exp);
    req_1 = 1'b0;
    @(negedge clk_i);
    check("l1_ack_clear", 32'(ack_1), 32'd0);
  endtask

  // Monitor: every ack of the main instance pops one expectation.
  always @(negedge clk_i) begin
    logic [31:0] e;
    logic        ee;
    if (start_i === 1'b1 && ack_o === 1'b1) begin
      n_acks++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got rdata %h expected no ack at %0t", rdata_o, $time);
      end else begin
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        check("rdata", rdata_o, e);
`ifdef DMEM_RANGE_CHECK_EN
        check("err_o", 32'(err_o), 32'(ee));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    start_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    req_1 = 1'b0; we_1 = 1'b0; addr_1 = 32'h0; wdata_1 = 32'h0;
    repeat (3) begin
      @(negedge clk_i);
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
    end
    req_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_idle", 32'(busy_o), 32'd0);

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom(), 1'b0);

    issue(1'b1, 32'h8,   32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h8,   32'h0,        1'b0);
    issue(1'b1, 32'h84,  32'h12345678, 1'b0);
    issue(1'b0, 32'h4,   32'h0,        1'b0);
    issue(1'b0, 32'h7,   32'h0,        1'b0);
    issue(1'b0, 32'h0,   32'h0,        1'b1);
    issue(1'b0, 32'h4,   32'h0,        1'b0);
    reset_mid_store();
    issue(1'b0, 32'h10,  32'h0,        1'b0);
    issue(1'b1, 32'h100, 32'h55AA55AA, 1'b0);
    issue(1'b0, 32'h0,   32'h0,        1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = 32'($urandom_range(0, 127));
      issue(1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 7) == 0));
    end

    issue1(1'b1, 32'h8, 32'hA5A55A5A, 32'hA5A55A5A);
    issue1(1'b0, 32'h8, 32'h0,        32'hA5A55A5A);

    repeat (2) @(negedge clk_i);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ack_count", 32'(n_acks), 32'(n_txn));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
